data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised byte-addressed, big-endian data memory for the MIPS datapath (MEM stage).
//  Supports sized loads/stores (lb/lbu/lh/lhu/lw, sb/sh/sw) behind a valid/ready request port.
//  Read latency is configurable; one request outstanding; response pulse with data/error.
// PARAMETERS
//  DEPTH_BYTES  256  memory size in bytes (power of 2, >=8)
//  ADDR_W       32   request address width; bits above log2(DEPTH_BYTES) must be 0
//  RD_LAT       1    read latency in cycles, 1..4
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous reset, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       block can accept; 1 only in IDLE
//  req_we      in   1       1=store, 0=load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads: 1 sign-extend, 0 zero-extend; ignored for stores
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data; byte/half taken from LSBs
//  resp_valid  out  1       one-cycle response pulse
//  resp_rdata  out  32      load result (LSB-aligned, extended); 0 for stores/errors
//  resp_err    out  1       qualified by resp_valid; 1 = request rejected
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; array NOT cleared.
//  - Accept on posedge with req_valid&req_ready (cycle T); all req_* sampled then only.
//  - FSM: IDLE -accept store-> RESP; IDLE -accept load-> WAIT (cnt=RD_LAT-1) or RESP if RD_LAT=1;
//    WAIT: cnt-- each cycle, ->RESP at cnt==0; RESP: resp_valid=1 one cycle, ->IDLE.
//  - Latency: store resp_valid at T+1; load resp_valid at T+RD_LAT. req_ready=0 from T+1 until
//    resp cycle inclusive; next accept earliest in cycle after resp (no back-to-back).
//  - Byte order big-endian: word at A = {m[A],m[A+1],m[A+2],m[A+3]}; half = {m[A],m[A+1]}.
//  - Store commits at the accept edge T: sb writes m[A]=wdata[7:0]; sh m[A..A+1]=wdata[15:0];
//    sw all four. Unselected bytes untouched. Load after store sees new data.
//  - Load result: byte/half placed in rdata LSBs, bits above filled with sign bit or 0.
//  - Error (resp_err=1, no write, rdata=0): req_size==11, or any byte of access >= DEPTH_BYTES
//    (no wrap-around), or misalignment when checking enabled (see CONFIGURATION).
//  - resp_rdata/resp_err hold last values after resp_valid drops until next response.
//  - Reset mid-operation: pending load dropped, no response; a store already accepted stays written.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: half at odd addr or word at addr[1:0]!=0 -> resp_err=1, no access.
//  Undefined: misaligned address silently aligned (half: addr[0]=0; word: addr[1:0]=0), err=0.
// STRUCTURE
//  Package mips_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state constants
//  IDLE/WAIT/RESP, load-extend helper function.
//  Sub-module dmem_bank: 4 byte lanes x DEPTH_BYTES/4, per-lane write enable, registered read;
//  controller owns FSM, lane steering, extension, range/alignment checks and latency pipeline.
// TESTING
//  1 sw 0x12345678 @0x10, lw @0x10 (RD_LAT=1) -> resp at T+1, rdata=0x12345678, err=0.
//  2 after 1: lb @0x10 -> 0x00000012; lb @0x12 signed after sb 0x80 @0x12 -> 0xFFFFFF80; lbu -> 0x80.
//  3 sh 0xBEEF @0x20, lh signed @0x20 -> 0xFFFFBEEF; lhu -> 0x0000BEEF; bytes 0x22/0x23 unchanged.
//  4 RD_LAT=3: lw accept at T -> resp_valid only at T+3, req_ready=0 T+1..T+3, req_valid held high ignored.
//  5 lw @DEPTH_BYTES-2 and size=11 -> err=1, rdata=0; mem unchanged; lh @0x21 -> err=1 (CHECK_EN)
//    else reads half @0x20.
//  6 rst asserted at T+1 of RD_LAT=3 load -> no resp_valid, outputs 0, req_ready=1 next cycle; memory retained.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS MEM-stage data memory:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   - controller FSM state type (IDLE / WAIT / RESP)
//   - load_extend(): picks a byte/half out of a big-endian 32-bit row and
//     sign- or zero-extends it into an LSB-aligned 32-bit result.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Row bit layout is big-endian: byte offset 0 lives in row[31:24].
  function automatic logic [31:0] load_extend(input logic [31:0] row,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = row[31:24];
      2'd1:    b = row[23:16];
      2'd2:    b = row[15:8];
      default: b = row[7:0];
    endcase
    h = off[1] ? row[15:0] : row[31:16];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = row;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus of the data memory controller.
// Handshake: a request transfers on a rising clock edge where req_valid and
//   req_ready are both 1; req_* are only sampled on that edge. req_ready is 1
//   only while the controller is idle. resp_valid is a one-cycle pulse;
//   resp_rdata/resp_err are meaningful with it and keep their value afterwards
//   until the next response.
// Signals:
//   req_valid/req_we/req_size/req_signed/req_addr/req_wdata  master -> slave
//   req_ready/resp_valid/resp_rdata/resp_err                  slave -> master
//   dbg_state  current controller FSM state (observation only)
// Modports: master (requester), slave (memory controller).
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(parameter int ADDR_W = 32);
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  state_t            dbg_state;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, dbg_state
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, dbg_state
  );
endinterface

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// Four byte lanes of ROWS entries each. Lane g holds byte offset g of a
// word row and maps to bits [31-8g -: 8] (big-endian). Per-lane write enable,
// registered read (data appears the cycle after i_re and then holds).
// Ports:
//   clk      clock
//   i_we     per-lane write enable (bit g = byte offset g)
//   i_re     read enable, captures the addressed row into o_rdata
//   i_row    row (word) index
//   i_wdata  write data, lane-aligned
//   o_rdata  registered read data
// Contents are not reset.
// -----------------------------------------------------------------------------
module dmem_bank #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic [3:0]       i_we,
  input  logic             i_re,
  input  logic [ROW_W-1:0] i_row,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [ROWS];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we[g]) r_mem[i_row] <= i_wdata[31-8*g -: 8];
      if (i_re)    r_q          <= r_mem[i_row];
    end

    assign o_rdata[31-8*g -: 8] = r_q;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressed big-endian data memory for the MIPS MEM stage with sized
// loads (lb/lbu/lh/lhu/lw) and stores (sb/sh/sw), one request outstanding.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset (memory contents are kept)
//   bus   data_mem_ctrl_if.slave request/response port
// Parameters:
//   DEPTH_BYTES  memory size in bytes (power of 2, >= 8)
//   ADDR_W       request address width; bits above log2(DEPTH_BYTES) must be 0
//   RD_LAT       load latency in cycles, 1..4
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, a misaligned half/word is rejected with
//                        resp_err; otherwise the address is silently aligned.
// Timing: a store responds in the cycle right after its accept edge, a load
// RD_LAT cycles after it. Stores commit on the accept edge itself.
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int RD_LAT      = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int MEM_AW = $clog2(DEPTH_BYTES);
  localparam int ROW_W  = MEM_AW - 2;

  state_t            r_state, w_state_n;
  logic [1:0]        r_cnt, w_cnt_n;

  // Request attributes captured on the accept edge.
  logic              r_we, r_sgn, r_err;
  logic [1:0]        r_size, r_off;
  // Last response, shown on the outputs between response pulses.
  logic [31:0]       r_hold_rdata;
  logic              r_hold_err;

  logic [ADDR_W-1:0] w_addr;
  logic              w_accept;
  logic              w_hi_bad, w_end_bad, w_size_bad, w_err;
  logic [1:0]        w_nb_m1, w_off;
  logic [3:0]        w_we;
  logic              w_re;
  logic [31:0]       w_wdata, w_bank_rdata, w_rdata;

  assign w_addr   = bus.req_addr;
  assign w_accept = bus.req_valid & (r_state == IDLE);

  // ---------------- request checks ----------------
  always_comb begin
    w_nb_m1 = 2'd0;
    case (bus.req_size)
      SZ_HALF: w_nb_m1 = 2'd1;
      SZ_WORD: w_nb_m1 = 2'd3;
      default: w_nb_m1 = 2'd0;
    endcase
  end

  assign w_size_bad = (bus.req_size == SZ_ILL);
  assign w_hi_bad   = ((w_addr >> MEM_AW) != '0);
  // Range is judged on the raw address so an access never wraps or is pulled
  // back into range by alignment.
  assign w_end_bad  = (({1'b0, w_addr[MEM_AW-1:0]} + {{(MEM_AW-1){1'b0}}, w_nb_m1})
                       > (MEM_AW+1)'(DEPTH_BYTES - 1));

`ifdef DMEM_ALIGN_CHECK_EN
  logic w_misal;
  assign w_misal = ((bus.req_size == SZ_HALF) && w_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (w_addr[1:0] != 2'b00));
  assign w_err   = w_size_bad | w_hi_bad | w_end_bad | w_misal;
  assign w_off   = w_addr[1:0];
`else
  assign w_err   = w_size_bad | w_hi_bad | w_end_bad;
  always_comb begin
    w_off = w_addr[1:0];
    case (bus.req_size)
      SZ_HALF: w_off = {w_addr[1], 1'b0};
      SZ_WORD: w_off = 2'b00;
      default: w_off = w_addr[1:0];
    endcase
  end
`endif

  // ---------------- store lane steering ----------------
  // Data is replicated across lanes so the enables alone pick the target bytes.
  always_comb begin
    w_we    = 4'b0000;
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      SZ_BYTE: begin
        w_wdata = {4{bus.req_wdata[7:0]}};
        w_we    = 4'b0001 << w_off;
      end
      SZ_HALF: begin
        w_wdata = {2{bus.req_wdata[15:0]}};
        w_we    = 4'b0011 << w_off;
      end
      SZ_WORD: w_we = 4'b1111;
      default: w_we = 4'b0000;
    endcase
    if (!(w_accept && bus.req_we && !w_err && !rst)) w_we = 4'b0000;
  end

  assign w_re = w_accept & ~bus.req_we & ~w_err;

  dmem_bank #(
    .ROWS  (DEPTH_BYTES / 4),
    .ROW_W (ROW_W)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_row   (w_addr[MEM_AW-1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_bank_rdata)
  );

  // ---------------- FSM ----------------
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_we || RD_LAT == 1) begin
            w_state_n = RESP;
          end else begin
            w_state_n = WAIT;
            w_cnt_n   = 2'(RD_LAT - 1);
          end
        end
      end
      WAIT: begin
        // Entered at T+1 with RD_LAT-1; leaving at cnt==1 puts RESP at T+RD_LAT.
        if (r_cnt == 2'd1) w_state_n = RESP;
        else               w_cnt_n   = r_cnt - 2'd1;
      end
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_we         <= 1'b0;
      r_sgn        <= 1'b0;
      r_err        <= 1'b0;
      r_size       <= SZ_BYTE;
      r_off        <= 2'd0;
      r_hold_rdata <= 32'd0;
      r_hold_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_we   <= bus.req_we;
        r_sgn  <= bus.req_signed;
        r_err  <= w_err;
        r_size <= bus.req_size;
        r_off  <= w_off;
      end
      if (r_state == RESP) begin
        r_hold_rdata <= w_rdata;
        r_hold_err   <= r_err;
      end
    end
  end

  // ---------------- response ----------------
  assign w_rdata = (r_we || r_err) ? 32'd0
                                   : load_extend(w_bank_rdata, r_size, r_off, r_sgn);

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = (r_state == RESP) ? w_rdata : r_hold_rdata;
  assign bus.resp_err   = (r_state == RESP) ? r_err   : r_hold_err;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controller instances (RD_LAT=1 and RD_LAT=3) sharing clock and reset,
// checked against a byte-array reference model of the memory.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
  import mips_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT [2] = '{1, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(32)) bus1 ();
  data_mem_ctrl_if #(.ADDR_W(32)) bus3 ();

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .RD_LAT(1)) dut_lat1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .RD_LAT(3)) dut_lat3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q [$];          // {err, rdata}
  logic [7:0]  ref_mem [2][DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input int d, input logic v, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_size = size;
      bus1.req_signed = sgn; bus1.req_addr = addr; bus1.req_wdata = wdata;
    end else begin
      bus3.req_valid = v; bus3.req_we = we; bus3.req_size = size;
      bus3.req_signed = sgn; bus3.req_addr = addr; bus3.req_wdata = wdata;
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) bus1.req_valid = v;
    else        bus3.req_valid = v;
  endtask

  task automatic sample(input int d, output logic rdy, output logic vld,
                        output logic err, output logic [31:0] rd);
    if (d == 0) begin
      rdy = bus1.req_ready; vld = bus1.resp_valid; err = bus1.resp_err; rd = bus1.resp_rdata;
    end else begin
      rdy = bus3.req_ready; vld = bus3.resp_valid; err = bus3.resp_err; rd = bus3.resp_rdata;
    end
  endtask

  // ---------------- reference model ----------------
  // Memory as a flat byte array; big-endian assembly with plain arithmetic.
  task automatic model(input int d, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic [32:0] res);
    int          nb;
    int          a;
    logic        err;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3);
    if ({32'd0, addr} + 64'(nb) > 64'(DEPTH)) err = 1'b1;
    a = 0;
    v = 32'd0;
    if (!err) begin
      a = int'(addr);
`ifdef DMEM_ALIGN_CHECK_EN
      if ((a % nb) != 0) err = 1'b1;
`else
      a = a - (a % nb);
`endif
    end
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[d][a+i] = 8'(wdata >> (8 * (nb - 1 - i)));
      end else begin
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[d][a+i]);
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      end
    end
    res = {err, v};
  endtask

  // ---------------- one transaction, checked end to end ----------------
  task automatic txn(input int d, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    logic [32:0] e;
    logic        rdy, vld, err;
    logic [31:0] rd;
    int          n;
    @(negedge clk);
    sample(d, rdy, vld, err, rd);
    check("ready_idle", 32'(rdy), 32'd1);
    drive(d, 1'b1, we, size, sgn, addr, wdata);
    model(d, we, size, sgn, addr, wdata, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) set_valid(d, 1'b0);
    n   = 0;
    vld = 1'b0;
    while (!vld && n < 10) begin
      @(negedge clk);
      n++;
      sample(d, rdy, vld, err, rd);
      check("ready_busy", 32'(rdy), 32'd0);
    end
    set_valid(d, 1'b0);
    check("latency", 32'(n), we ? 32'd1 : 32'(LAT[d]));
    e = exp_q.pop_front();
    if (vld) begin
      check("rdata", rd, e[31:0]);
      check("err", 32'(err), 32'(e[32]));
      @(negedge clk);
      sample(d, rdy, vld, err, rd);
      check("pulse_end", 32'(vld), 32'd0);
      check("hold_rdata", rd, e[31:0]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        rdy, vld, err;
    logic [31:0] rd;
    int          d, r;
    logic [1:0]  sz;
    logic [31:0] ad;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(k, rdy, vld, err, rd);
      check("rst_ready", 32'(rdy), 32'd1);
      check("rst_valid", 32'(vld), 32'd0);
      check("rst_rdata", rd, 32'd0);
      check("rst_err",   32'(err), 32'd0);
    end
    check("rst_state", 32'(bus1.dbg_state), 32'(IDLE));
    rst = 1'b0;

    // give both memories known contents
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a += 4) txn(k, 1'b1, SZ_WORD, 1'b0, 32'(a), $urandom, 1'b0);

    // sw / lw round trip
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1234_5678, 1'b0);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b0);
    // bytes, signed and unsigned
    txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'd0, 1'b0);
    txn(0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hFFFF_FF80, 1'b0);
    txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b0);
    // halves, neighbours untouched
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h20, 32'h1234_BEEF, 1'b0);
    txn(0, 1'b0, SZ_HALF, 1'b1, 32'h20, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h20, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h22, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h23, 32'd0, 1'b0);
    // long latency with req_valid held during the wait
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b1);
    txn(1, 1'b0, SZ_HALF, 1'b1, 32'h32, 32'd0, 1'b1);
    // errors: out of range, illegal size, misaligned half
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'(DEPTH - 2), 32'd0, 1'b0);
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'(DEPTH - 2), 32'hDEAD_BEEF, 1'b0);
    txn(0, 1'b0, SZ_ILL,  1'b0, 32'h10, 32'd0, 1'b0);
    txn(0, 1'b1, SZ_ILL,  1'b0, 32'h10, 32'hCAFE_F00D, 1'b0);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'(DEPTH - 4), 32'd0, 1'b0);
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'd0, 1'b0);
    txn(1, 1'b0, SZ_BYTE, 1'b0, 32'h0001_0000, 32'd0, 1'b0);
    txn(1, 1'b1, SZ_HALF, 1'b0, 32'(DEPTH - 1), 32'h0000_5A5A, 1'b0);
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'(DEPTH - 4), 32'd0, 1'b0);

    // reset in the middle of a RD_LAT=3 load
    txn(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h8765_4321, 1'b0);
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
    @(posedge clk);
    #1;
    set_valid(1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(1, rdy, vld, err, rd);
    check("midrst_ready", 32'(rdy), 32'd1);
    check("midrst_rdata", rd, 32'd0);
    check("midrst_err",   32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(1, rdy, vld, err, rd);
      check("midrst_no_resp", 32'(vld), 32'd0);
    end
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0, 1'b0);
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : SZ_ILL;
      ad = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 4));
      txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
